fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetchq_pkg.sv | 21 ++
 rtl/fetchq_mem.sv | 25 ++
 rtl/fetch_queue.sv | 103 ++++++++++
 tb/tb_fetch_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetchq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetchq_pkg;

    localparam int EXC_W        = 8;
    localparam int TLB_EXC_W    = 5;
    localparam int ENTRY_ADDR_W = 32;
    localparam int ENTRY_DATA_W = 32;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] pc;
        logic [ENTRY_DATA_W-1:0] instr;
        logic [EXC_W-1:0]        except;
        logic [TLB_EXC_W-1:0]    tlb_except;
    } fetchq_entry_t;

    // Packed storage width of one entry for arbitrary PC/instruction widths.
    function automatic int entryBits(input int addrW, input int dataW);
        return addrW + dataW + EXC_W + TLB_EXC_W;
    endfunction

endpackage

// File: rtl/fetchq_mem.sv
// Fetch queue entry storage: register array, one write port, one asynchronous read port.
module fetchq_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 77
) (
    input  logic                     clk,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData
);

    logic [WIDTH-1:0] store [DEPTH];

    // Contents are never cleared; validity lives in the queue control.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            store[wrAddr] <= wrData;
        end
    end

    assign rdData = store[rdAddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode, with flush and async active-low reset.
// Optional same-cycle empty-queue bypass enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue
    import fetchq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [ADDR_W-1:0]          push_pc,
    input  logic [DATA_W-1:0]          push_instr,
    input  logic [EXC_W-1:0]           push_except,
    input  logic [TLB_EXC_W-1:0]       push_tlb_except,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [ADDR_W-1:0]          pop_pc,
    output logic [DATA_W-1:0]          pop_instr,
    output logic [EXC_W-1:0]           pop_except,
    output logic [TLB_EXC_W-1:0]       pop_tlb_except,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = entryBits(ADDR_W, DATA_W);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]   headPtr;
    logic [PTR_W-1:0]   tailPtr;
    logic [CNT_W-1:0]   countQ;
    logic [ENTRY_W-1:0] wrData;
    logic [ENTRY_W-1:0] rdData;
    logic               isEmpty;
    logic               bypassHit;
    logic               doPush;
    logic               doPop;

    assign count  = countQ;
    assign wrData = {push_pc, push_instr, push_except, push_tlb_except};

    always_comb begin
        isEmpty    = (countQ == '0);
        push_ready = (countQ < FULL_COUNT);
`ifdef FETCHQ_BYPASS_EN
        bypassHit  = rst && isEmpty && push_valid && !flush;
`else
        bypassHit  = 1'b0;
`endif
        pop_valid  = !isEmpty || bypassHit;
        // A bypassed entry consumed this cycle is never written into storage.
        doPush     = push_valid && push_ready && !flush && !(bypassHit && pop_ready);
        doPop      = !isEmpty && pop_ready && !flush;

        {pop_pc, pop_instr, pop_except, pop_tlb_except} = '0;
        if (bypassHit) begin
            {pop_pc, pop_instr, pop_except, pop_tlb_except} = wrData;
        end else if (!isEmpty) begin
            {pop_pc, pop_instr, pop_except, pop_tlb_except} = rdData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            headPtr <= '0;
            tailPtr <= '0;
            countQ  <= '0;
        end else if (flush) begin
            headPtr <= '0;
            tailPtr <= '0;
            countQ  <= '0;
        end else begin
            if (doPush) begin
                tailPtr <= tailPtr + PTR_W'(1);
            end
            if (doPop) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   countQ <= countQ + CNT_W'(1);
                2'b01:   countQ <= countQ - CNT_W'(1);
                default: countQ <= countQ;
            endcase
        end
    end

    fetchq_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) uMem (
        .clk    (clk),
        .wrEn   (doPush),
        .wrAddr (tailPtr),
        .wrData (wrData),
        .rdAddr (headPtr),
        .rdData (rdData)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;
    import fetchq_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 push_valid;
    logic                 push_ready;
    logic [ADDR_W-1:0]    push_pc;
    logic [DATA_W-1:0]    push_instr;
    logic [EXC_W-1:0]     push_except;
    logic [TLB_EXC_W-1:0] push_tlb_except;
    logic                 pop_valid;
    logic                 pop_ready;
    logic [ADDR_W-1:0]    pop_pc;
    logic [DATA_W-1:0]    pop_instr;
    logic [EXC_W-1:0]     pop_except;
    logic [TLB_EXC_W-1:0] pop_tlb_except;
    logic [2:0]           count;

    int total = 0;
    int bad   = 0;
    fetchq_entry_t model[$];

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .push_valid      (push_valid),
        .push_ready      (push_ready),
        .push_pc         (push_pc),
        .push_instr      (push_instr),
        .push_except     (push_except),
        .push_tlb_except (push_tlb_except),
        .pop_valid       (pop_valid),
        .pop_ready       (pop_ready),
        .pop_pc          (pop_pc),
        .pop_instr       (pop_instr),
        .pop_except      (pop_except),
        .pop_tlb_except  (pop_tlb_except),
        .count           (count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit bypassNow();
`ifdef FETCHQ_BYPASS_EN
        return (rst === 1'b1) && model.size() == 0 && push_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutputs(input string tag);
        fetchq_entry_t exp;
        bit            expValid;
        exp      = '0;
        expValid = (model.size() != 0) || bypassNow();
        if (bypassNow()) begin
            exp.pc = push_pc; exp.instr = push_instr;
            exp.except = push_except; exp.tlb_except = push_tlb_except;
        end else if (model.size() != 0) begin
            exp = model[0];
        end
        check({tag, ".pop_valid"},  64'(pop_valid),      64'(expValid));
        check({tag, ".pop_pc"},     64'(pop_pc),         64'(exp.pc));
        check({tag, ".pop_instr"},  64'(pop_instr),      64'(exp.instr));
        check({tag, ".pop_except"}, 64'(pop_except),     64'(exp.except));
        check({tag, ".pop_tlb"},    64'(pop_tlb_except), 64'(exp.tlb_except));
        check({tag, ".count"},      64'(count),          64'(model.size()));
        check({tag, ".push_ready"}, 64'(push_ready),     64'(model.size() < DEPTH));
    endtask

    task automatic updateModel();
        fetchq_entry_t e;
        bit            byp;
        bit            accept;
        bit            popped;
        byp = bypassNow();
        if (flush) begin
            model.delete();
        end else begin
            popped = (model.size() != 0) && pop_ready;
            accept = push_valid && (model.size() < DEPTH) && !(byp && pop_ready);
            if (popped) void'(model.pop_front());
            if (accept) begin
                e.pc = push_pc; e.instr = push_instr;
                e.except = push_except; e.tlb_except = push_tlb_except;
                model.push_back(e);
            end
        end
    endtask

    task automatic drive(input bit v, input logic [ADDR_W-1:0] pc, input bit rdy, input bit fl);
        push_valid      = v;
        push_pc         = pc;
        push_instr      = pc ^ 32'hA5A5_0000;
        push_except     = 8'(pc[7:0]);
        push_tlb_except = 5'(pc[4:0]);
        pop_ready       = rdy;
        flush           = fl;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        checkOutputs(tag);
        @(posedge clk);
        updateModel();
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        #12;
        checkOutputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full, then a dropped fifth push, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            cycle("fill");
        end
        drive(1'b1, 32'h110, 1'b0, 1'b0);
        cycle("full_drop");
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            cycle("drain");
        end

        // Exception bits carried through unchanged.
        drive(1'b1, 32'h180, 1'b0, 1'b0);
        push_instr = '0; push_except = 8'h80; push_tlb_except = 5'h10;
        cycle("exc_push");
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle("exc_pop");
        cycle("exc_empty");

        // Steady push+pop at count=2 across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
            cycle("wrap_pre");
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h408 + 32'(4 * i), 1'b1, 1'b0);
            cycle("wrap");
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle("wrap_drain");
        cycle("wrap_drain");

        // Flush at count=3 with a concurrent push that must vanish.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
            cycle("flush_pre");
        end
        drive(1'b1, 32'h200, 1'b1, 1'b1);
        cycle("flush");
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle("flush_after");
        cycle("flush_after2");

        // Empty queue push with pop_ready: bypass or one-cycle latency.
        drive(1'b1, 32'h300, 1'b1, 1'b0);
        cycle("bypass");
        drive(1'b0, '0, 1'b1, 1'b0);
        cycle("bypass_next");
        cycle("bypass_idle");

        // Asynchronous reset with two entries held.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0);
            cycle("rst_pre");
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model.delete();
        checkOutputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle("post_rst");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0));
            push_instr      = $urandom;
            push_except     = 8'($urandom);
            push_tlb_except = 5'($urandom);
            cycle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
